useq_controller: RTL and testbench

- Run-control sequencer for the CSCvon8 microcoded datapath; replaces the bare microstep counter in front of the decoder ROM.
- Owns the microstep count and forms the decoder index {IR, microstep}.
- Produces a global datapath clock-enable so the CPU can free-run, halt at instruction boundaries, single-step one instruction via a four-phase handshake, and stop on a PC breakpoint.
- Also keeps an executed-instruction counter and traps runaway microcode.

---
 rtl/useq_controller_if.sv | 37 +++
 rtl/useq_controller.sv | 119 +++++++++++
 tb/tb_useq_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/useq_controller_if.sv
// rtl/useq_controller_if.sv - run-control sequencer bus bundle
interface useq_controller_if #(
  parameter int WordSize    = 8,
  parameter int AddressSize = 16,
  parameter int USize       = 4,
  parameter int CountSize   = 16
);
  logic [WordSize-1:0]       i_ir;
  logic                      i_usreset;
  logic [AddressSize-1:0]    i_pc;
  logic                      i_run;
  logic                      i_step_req;
  logic                      o_step_ack;
  logic                      i_bp_en;
  logic [AddressSize-1:0]    i_bp_addr;
  logic                      o_clk_en;
  logic [WordSize+USize-1:0] o_decode_index;
  logic [USize-1:0]          o_ustep;
  logic [1:0]                o_state;
  logic                      o_bp_hit;
  logic                      o_uerr;
  logic [CountSize-1:0]      o_icount;

  // Front panel / CPU side that drives the sequencer
  modport master (
    output i_ir, i_usreset, i_pc, i_run, i_step_req, i_bp_en, i_bp_addr,
    input  o_step_ack, o_clk_en, o_decode_index, o_ustep, o_state,
           o_bp_hit, o_uerr, o_icount
  );

  // The sequencer itself
  modport slave (
    input  i_ir, i_usreset, i_pc, i_run, i_step_req, i_bp_en, i_bp_addr,
    output o_step_ack, o_clk_en, o_decode_index, o_ustep, o_state,
           o_bp_hit, o_uerr, o_icount
  );
endinterface

// File: rtl/useq_controller.sv
// rtl/useq_controller.sv - microstep sequencer with run/halt/step/breakpoint control
module useq_controller #(
  parameter int WordSize    = 8,
  parameter int AddressSize = 16,
  parameter int USize       = 4,
  parameter int CountSize   = 16
) (
  input logic              i_clk,
  input logic              i_rst_n,
  useq_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    STEP = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [USize-1:0]     USTEP_ONE  = 1;
  localparam logic [CountSize-1:0] ICOUNT_ONE = 1;

  state_t               state;
  logic [USize-1:0]     ustep;
  logic [CountSize-1:0] icount;
  logic                 step_ack;
  logic                 bp_hit;
  logic                 uerr;
  logic                 skip;

  logic bp_match;
  logic clk_en;
  logic boundary;
  logic overflow;

  // Breakpoint compare and datapath enable; a hit suppresses the enable in the same cycle
  always_comb begin
    bp_match = bus.i_bp_en && (ustep == '0) && (bus.i_pc == bus.i_bp_addr) && !skip;
    clk_en   = ((state == RUN) && !bp_match) || (state == STEP);
    boundary = clk_en && !bus.i_usreset;
    overflow = clk_en && bus.i_usreset && (ustep == '1);
  end

  assign bus.o_clk_en       = clk_en;
  assign bus.o_decode_index = {bus.i_ir, ustep};
  assign bus.o_ustep        = ustep;
  assign bus.o_state        = state;
  assign bus.o_step_ack     = step_ack;
  assign bus.o_bp_hit       = bp_hit;
  assign bus.o_uerr         = uerr;
  assign bus.o_icount       = icount;

  // Microstep/instruction counters and run-control state machine
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= HALT;
      ustep    <= '0;
      icount   <= '0;
      step_ack <= 1'b0;
      bp_hit   <= 1'b0;
      uerr     <= 1'b0;
      skip     <= 1'b0;
    end else begin
      if (clk_en) begin
        // Overflow falls out of the increment wrapping to zero
        if (boundary) begin
          ustep  <= '0;
          icount <= icount + ICOUNT_ONE;
        end else begin
          ustep <= ustep + USTEP_ONE;
        end
        // Once the resumed instruction has moved past microstep 0 it can no longer re-hit
        if (boundary || (ustep != '0)) skip <= 1'b0;
        if (overflow) uerr <= 1'b1;
      end

      case (state)
        RUN: begin
          if (bp_match) begin
            state  <= HALT;
            bp_hit <= 1'b1;
          end else if (overflow || (boundary && !bus.i_run)) begin
            state <= HALT;
          end
        end
        HALT: begin
          // A microcode trap keeps the sequencer parked until reset
          if (!uerr) begin
            if (bus.i_run) begin
              state  <= RUN;
              bp_hit <= 1'b0;
              skip   <= 1'b1;
            end else if (bus.i_step_req && !step_ack) begin
              state  <= STEP;
              bp_hit <= 1'b0;
              skip   <= 1'b1;
            end
          end
        end
        STEP: begin
          if (overflow) begin
            state <= HALT;
          end else if (boundary) begin
            state    <= DONE;
            step_ack <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.i_step_req) begin
            step_ack <= 1'b0;
            state    <= HALT;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_useq_controller.sv
// tb/tb_useq_controller.sv - randomized scoreboard bench for useq_controller
module tb_useq_controller;

  localparam int NCYC = 4000;

  typedef struct {
    logic [1:0]  st;
    logic [3:0]  us;
    logic [15:0] ic;
    logic        ack;
    logic        bph;
    logic        uerr;
    logic        en;
    logic [11:0] di;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  int   n_cmp;
  int   n_fail;

  useq_controller_if bus ();

  useq_controller dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: observable sequencer status
  // mode: 0 running, 1 halted, 2 stepping, 3 step finished (matches o_state)
  int mode, us, ic;
  bit ack, bph, uerr, skip;

  // Environment: program being executed
  int pc, ir, cur_len, bp_addr, halt_wait;
  bit run, step_req, bp_en, usreset;

  task automatic model_reset();
    mode = 1; us = 0; ic = 0; ack = 0; bph = 0; uerr = 0; skip = 0;
  endtask

  task automatic new_instr();
    cur_len = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 6);
    ir = $urandom_range(0, 255);
    if ($urandom_range(0, 3) == 0) bp_addr = (pc + $urandom_range(0, 3)) % 65536;
  endtask

  // Monitor: compares every cycle's DUT outputs against the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("state",        32'(bus.o_state),        32'(e.st));
        check("ustep",        32'(bus.o_ustep),        32'(e.us));
        check("icount",       32'(bus.o_icount),       32'(e.ic));
        check("step_ack",     32'(bus.o_step_ack),     32'(e.ack));
        check("bp_hit",       32'(bus.o_bp_hit),       32'(e.bph));
        check("uerr",         32'(bus.o_uerr),         32'(e.uerr));
        check("clk_en",       32'(bus.o_clk_en),       32'(e.en));
        check("decode_index", 32'(bus.o_decode_index), 32'(e.di));
      end
    end
  end

  // Stimulus: drives a random program and run/step/breakpoint activity, predicts outputs
  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    run = 0; step_req = 0; bp_en = 0; bp_addr = 0; pc = 0; halt_wait = 0;
    new_instr();
    bus.i_ir = '0; bus.i_usreset = 1'b1; bus.i_pc = '0; bus.i_run = 1'b0;
    bus.i_step_req = 1'b0; bus.i_bp_en = 1'b0; bus.i_bp_addr = '0;
    model_reset();
    @(posedge clk); #2;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      bit bpm, en, bnd, ovf;
      exp_t e;
      int n_mode, n_us, n_ic;
      bit n_ack, n_bph, n_uerr, n_skip;

      rst_n = ($urandom_range(0, 499) != 0);
      if (uerr) begin
        halt_wait++;
        if (halt_wait > 20) rst_n = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) run = !run;
      if (!step_req) step_req = ($urandom_range(0, 5) == 0);
      else if (ack) step_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) bp_en = !bp_en;
      usreset = !(cur_len != 0 && us == cur_len - 1);

      bus.i_ir = ir[7:0]; bus.i_usreset = usreset; bus.i_pc = pc[15:0];
      bus.i_run = run; bus.i_step_req = step_req; bus.i_bp_en = bp_en;
      bus.i_bp_addr = bp_addr[15:0];

      // What should be visible during this cycle
      bpm = bp_en && us == 0 && pc == bp_addr && !skip;
      en  = (mode == 0 && !bpm) || mode == 2;
      e.st = 2'(mode); e.us = 4'(us); e.ic = 16'(ic); e.ack = ack; e.bph = bph;
      e.uerr = uerr; e.en = en; e.di = {ir[7:0], us[3:0]};
      q.push_back(e);

      // What the coming edge should do
      bnd = en && !usreset;
      ovf = en && usreset && us == 15;
      n_mode = mode; n_us = us; n_ic = ic; n_ack = ack; n_bph = bph;
      n_uerr = uerr; n_skip = skip;
      if (en) begin
        n_us = bnd ? 0 : (us + 1) % 16;
        if (bnd) n_ic = (ic + 1) % 65536;
        if (ovf) n_uerr = 1;
        if (bnd || us != 0) n_skip = 0;
      end
      if (mode == 0) begin
        if (bpm) begin n_mode = 1; n_bph = 1; end
        else if (ovf || (bnd && !run)) n_mode = 1;
      end else if (mode == 1) begin
        if (!uerr && run) begin n_mode = 0; n_bph = 0; n_skip = 1; end
        else if (!uerr && step_req && !ack) begin n_mode = 2; n_bph = 0; n_skip = 1; end
      end else if (mode == 2) begin
        if (ovf) n_mode = 1;
        else if (bnd) begin n_mode = 3; n_ack = 1; end
      end else begin
        if (!step_req) begin n_mode = 1; n_ack = 0; end
      end

      if (!rst_n) begin
        model_reset();
        pc = 0; halt_wait = 0;
        new_instr();
      end else begin
        mode = n_mode; us = n_us; ic = n_ic; ack = n_ack; bph = n_bph;
        uerr = n_uerr; skip = n_skip;
        if (bnd) begin
          pc = (pc + 1) % 65536;
          new_instr();
        end
      end

      @(posedge clk); #2;
    end
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
